chan_msg_arbiter: RTL and testbench

- Shares the single inter-CPU message port toward the dispatcher between N_REQ channel controllers.
- Each controller drives a CHN transaction: a CPU_R_CHAN_GET or CPU_R_CHAN_SET message, then a CPU_R_THREAD_ADDRESS message, then it waits for a response.
- The arbiter grants one requester at a time in round-robin order. It forwards that requester's message pulses with registered timing and routes the dispatcher response back only to the granted requester.
- The grant is held until a terminal response arrives, so the two messages and the response of one transaction are never interleaved with another requester's.

---
 rtl/chan_msg_arbiter_if.sv | 72 +++++++
 rtl/chan_msg_arbiter.sv | 245 ++++++++++++++++++++++++
 tb/tb_chan_msg_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chan_msg_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : chan_msg_arbiter_if
// Description : Request/response bus between the channel controllers, the
//               message arbiter and the dispatcher. Also provides default
//               values for the CPU message codes used by the arbiter.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------

`ifndef CPU_R_CHAN_GET
`define CPU_R_CHAN_GET          8'h41
`endif
`ifndef CPU_R_CHAN_SET
`define CPU_R_CHAN_SET          8'h42
`endif
`ifndef CPU_R_THREAD_ADDRESS
`define CPU_R_THREAD_ADDRESS    8'h43
`endif
`ifndef CPU_R_CHAN_NO_RESULTS
`define CPU_R_CHAN_NO_RESULTS   8'h44
`endif
`ifndef CPU_R_CHAN_RES_RD
`define CPU_R_CHAN_RES_RD       8'h45
`endif
`ifndef CPU_R_CHAN_RES_WR
`define CPU_R_CHAN_RES_WR       8'h46
`endif

interface chan_msg_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int MSG_W  = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  // Requester side
  logic [N_REQ-1:0]        req_i;
  logic [N_REQ-1:0]        req_pulse_i;
  logic [N_REQ*MSG_W-1:0]  req_msg_i;
  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic [N_REQ*ADDR_W-1:0] req_addr_i;
  logic [N_REQ-1:0]        grant_o;
  logic [N_REQ*MSG_W-1:0]  rsp_msg_o;
  logic [N_REQ*DATA_W-1:0] rsp_data_o;
  // Dispatcher side
  logic [MSG_W-1:0]        msg_out;
  logic [DATA_W-1:0]       data_out;
  logic [ADDR_W-1:0]       addr_out;
  logic                    msg_pulse_o;
  logic [MSG_W-1:0]        rsp_msg_i;
  logic [DATA_W-1:0]       rsp_data_i;
  // Status
  logic                    busy_o;
  logic                    tmo_o;

  // Controllers and dispatcher (drive requests and responses)
  modport master (
    output req_i, req_pulse_i, req_msg_i, req_data_i, req_addr_i,
    output rsp_msg_i, rsp_data_i,
    input  grant_o, rsp_msg_o, rsp_data_o,
    input  msg_out, data_out, addr_out, msg_pulse_o, busy_o, tmo_o
  );

  // Arbiter
  modport slave (
    input  req_i, req_pulse_i, req_msg_i, req_data_i, req_addr_i,
    input  rsp_msg_i, rsp_data_i,
    output grant_o, rsp_msg_o, rsp_data_o,
    output msg_out, data_out, addr_out, msg_pulse_o, busy_o, tmo_o
  );
endinterface

`default_nettype wire

// File: rtl/chan_msg_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : chan_msg_arbiter
// Description : Round-robin arbiter sharing the inter-CPU message port
//               between N_REQ channel controllers. A grant is held for a
//               whole CHN transaction (two messages plus a terminal
//               response). Optional response timeout enabled by defining
//               the macro CHAN_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------

`ifndef CPU_R_CHAN_NO_RESULTS
`define CPU_R_CHAN_NO_RESULTS   8'h44
`endif
`ifndef CPU_R_CHAN_RES_RD
`define CPU_R_CHAN_RES_RD       8'h45
`endif
`ifndef CPU_R_CHAN_RES_WR
`define CPU_R_CHAN_RES_WR       8'h46
`endif

module chan_msg_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MSG_W   = 8,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_oe,
  input  logic              disp_online,
  chan_msg_arbiter_if.slave bus
);

  localparam int IW = $clog2(N_REQ);

  localparam logic [MSG_W-1:0] C_NO_RES = MSG_W'(`CPU_R_CHAN_NO_RESULTS);
  localparam logic [MSG_W-1:0] C_RES_RD = MSG_W'(`CPU_R_CHAN_RES_RD);
  localparam logic [MSG_W-1:0] C_RES_WR = MSG_W'(`CPU_R_CHAN_RES_WR);

  // Elaboration-time guard on the supported parameter ranges
  if (N_REQ < 2 || N_REQ > 8 || TMO_CYC < 1 || TMO_CYC > 255) begin : g_param_check
    $error("chan_msg_arbiter: unsupported N_REQ or TMO_CYC");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [IW-1:0]           r_gidx, w_gidx_nxt;
  logic [IW-1:0]           r_ptr, w_ptr_nxt;
  logic                    r_pulse, w_pulse_nxt;
  logic [MSG_W-1:0]        r_msg, w_msg_nxt;
  logic [DATA_W-1:0]       r_data, w_data_nxt;
  logic [ADDR_W-1:0]       r_addr, w_addr_nxt;
  logic [N_REQ*MSG_W-1:0]  r_rsp_msg, w_rsp_msg_nxt;
  logic [N_REQ*DATA_W-1:0] r_rsp_data, w_rsp_data_nxt;

  logic                    w_win_found;
  logic [IW-1:0]           w_win_idx;
  logic                    w_active;
  logic [N_REQ-1:0]        w_grant;
  logic                    w_g_req;
  logic                    w_g_pulse;
  logic [MSG_W-1:0]        w_g_msg;
  logic [DATA_W-1:0]       w_g_data;
  logic [ADDR_W-1:0]       w_g_addr;
  logic                    w_rsp_term;
  logic [IW-1:0]           w_ptr_inc;

`ifdef CHAN_ARB_TIMEOUT_EN
  logic [7:0]              r_tmo_cnt, w_cnt_nxt, w_cnt_inc;
  logic                    r_tmo, w_tmo_nxt;
  assign w_cnt_inc = r_tmo_cnt + 8'd1;
`endif

  assign w_active   = (r_state == S_GRANT) || (r_state == S_WAIT);
  assign w_g_req    = bus.req_i[r_gidx];
  assign w_g_pulse  = bus.req_pulse_i[r_gidx];
  assign w_g_msg    = bus.req_msg_i[int'(r_gidx)*MSG_W +: MSG_W];
  assign w_g_data   = bus.req_data_i[int'(r_gidx)*DATA_W +: DATA_W];
  assign w_g_addr   = bus.req_addr_i[int'(r_gidx)*ADDR_W +: ADDR_W];
  assign w_rsp_term = (bus.rsp_msg_i == C_NO_RES) || (bus.rsp_msg_i == C_RES_RD) ||
                      (bus.rsp_msg_i == C_RES_WR);
  assign w_ptr_inc  = (int'(r_gidx) == N_REQ-1) ? '0 : r_gidx + 1'b1;

  // Round-robin search: first requester at or above the pointer, wrapping
  always_comb begin : p_winner
    int            j;
    logic [IW-1:0] j_idx;
    j           = 0;
    j_idx       = '0;
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      j_idx = IW'(j);
      if (!w_win_found && bus.req_i[j_idx]) begin
        w_win_found = 1'b1;
        w_win_idx   = j_idx;
      end
    end
  end

  // One-hot grant is visible while the transaction owns the port
  always_comb begin : p_grant
    w_grant = '0;
    if (w_active) w_grant[r_gidx] = 1'b1;
  end

  // Next-state and next registered-output logic
  always_comb begin : p_next
    w_state_nxt    = r_state;
    w_gidx_nxt     = r_gidx;
    w_ptr_nxt      = r_ptr;
    w_pulse_nxt    = 1'b0;
    w_msg_nxt      = '0;
    w_data_nxt     = '0;
    w_addr_nxt     = '0;
    w_rsp_msg_nxt  = '0;
    w_rsp_data_nxt = '0;
`ifdef CHAN_ARB_TIMEOUT_EN
    w_cnt_nxt      = r_tmo_cnt;
    w_tmo_nxt      = 1'b0;
`endif

    // Owner's message pulses are forwarded in both GRANT and WAIT
    if (w_active && w_g_pulse) begin
      w_pulse_nxt = 1'b1;
      w_msg_nxt   = w_g_msg;
      w_data_nxt  = w_g_data;
      w_addr_nxt  = w_g_addr;
    end

    case (r_state)
      S_IDLE: begin
        if (disp_online && w_win_found) begin
          w_gidx_nxt  = w_win_idx;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_g_pulse) begin
          w_state_nxt = S_WAIT;
`ifdef CHAN_ARB_TIMEOUT_EN
          w_cnt_nxt   = 8'd0;
`endif
        end else if (!w_g_req) begin
          // Requester gave up before sending anything: no response expected
          w_state_nxt = S_RELEASE;
        end
      end
      S_WAIT: begin
        w_rsp_msg_nxt[int'(r_gidx)*MSG_W +: MSG_W]    = bus.rsp_msg_i;
        w_rsp_data_nxt[int'(r_gidx)*DATA_W +: DATA_W] = bus.rsp_data_i;
        if (w_rsp_term) begin
          w_state_nxt = S_RELEASE;
        end
`ifdef CHAN_ARB_TIMEOUT_EN
        else if (w_cnt_inc == 8'(TMO_CYC)) begin
          w_tmo_nxt   = 1'b1;
          w_rsp_msg_nxt[int'(r_gidx)*MSG_W +: MSG_W]    = C_NO_RES;
          w_rsp_data_nxt[int'(r_gidx)*DATA_W +: DATA_W] = '0;
          w_state_nxt = S_RELEASE;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
`endif
      end
      S_RELEASE: begin
        w_ptr_nxt   = w_ptr_inc;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; a low clk_oe freezes state and clears pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gidx     <= '0;
      r_ptr      <= '0;
      r_pulse    <= 1'b0;
      r_msg      <= '0;
      r_data     <= '0;
      r_addr     <= '0;
      r_rsp_msg  <= '0;
      r_rsp_data <= '0;
    end else if (clk_oe) begin
      r_state    <= w_state_nxt;
      r_gidx     <= w_gidx_nxt;
      r_ptr      <= w_ptr_nxt;
      r_pulse    <= w_pulse_nxt;
      r_msg      <= w_msg_nxt;
      r_data     <= w_data_nxt;
      r_addr     <= w_addr_nxt;
      r_rsp_msg  <= w_rsp_msg_nxt;
      r_rsp_data <= w_rsp_data_nxt;
    end else begin
      r_pulse    <= 1'b0;
      r_msg      <= '0;
      r_data     <= '0;
      r_addr     <= '0;
      r_rsp_msg  <= '0;
      r_rsp_data <= '0;
    end
  end

`ifdef CHAN_ARB_TIMEOUT_EN
  // Response timeout counter and abort pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= 8'd0;
      r_tmo     <= 1'b0;
    end else if (clk_oe) begin
      r_tmo_cnt <= w_cnt_nxt;
      r_tmo     <= w_tmo_nxt;
    end else begin
      r_tmo     <= 1'b0;
    end
  end
  assign bus.tmo_o = r_tmo;
`else
  assign bus.tmo_o = 1'b0;
`endif

  assign bus.grant_o     = w_grant;
  assign bus.busy_o      = w_active;
  assign bus.msg_pulse_o = r_pulse;
  assign bus.msg_out     = r_msg;
  assign bus.data_out    = r_data;
  assign bus.addr_out    = r_addr;
  assign bus.rsp_msg_o   = r_rsp_msg;
  assign bus.rsp_data_o  = r_rsp_data;

endmodule

`default_nettype wire

// File: tb/tb_chan_msg_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_chan_msg_arbiter
// Description : Self-checking bench for chan_msg_arbiter with a
//               transaction-level reference model (owner / pointer / phase).
//               Define CHAN_ARB_TIMEOUT_EN to also exercise the timeout.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------

`ifndef CPU_R_CHAN_GET
`define CPU_R_CHAN_GET          8'h41
`endif
`ifndef CPU_R_CHAN_SET
`define CPU_R_CHAN_SET          8'h42
`endif
`ifndef CPU_R_THREAD_ADDRESS
`define CPU_R_THREAD_ADDRESS    8'h43
`endif
`ifndef CPU_R_CHAN_NO_RESULTS
`define CPU_R_CHAN_NO_RESULTS   8'h44
`endif
`ifndef CPU_R_CHAN_RES_RD
`define CPU_R_CHAN_RES_RD       8'h45
`endif
`ifndef CPU_R_CHAN_RES_WR
`define CPU_R_CHAN_RES_WR       8'h46
`endif

module tb_chan_msg_arbiter;

  localparam int N   = 4;
  localparam int MW  = 8;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  logic clk_oe;
  logic disp_online;

  chan_msg_arbiter_if #(.N_REQ(N), .MSG_W(MW), .DATA_W(DW), .ADDR_W(AW)) bus ();

  chan_msg_arbiter #(
    .N_REQ(N), .MSG_W(MW), .DATA_W(DW), .ADDR_W(AW), .TMO_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .clk_oe(clk_oe), .disp_online(disp_online), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int  m_own  = -1;   // granted requester, -1 when the port is free
  int  m_last = 0;    // requester released most recently
  int  m_ptr  = 0;    // round-robin start point
  int  m_cnt  = 0;    // qualified cycles spent waiting for a response
  bit  m_rel  = 0;    // in the one-cycle release gap
  bit  m_fwd  = 0;    // owner has already sent a message

  logic              e_pulse, e_tmo;
  logic [MW-1:0]     e_msg;
  logic [DW-1:0]     e_data;
  logic [AW-1:0]     e_addr;
  logic [N*MW-1:0]   e_rsp_msg;
  logic [N*DW-1:0]   e_rsp_data;

  function automatic bit is_term(input logic [7:0] c);
    return (c == `CPU_R_CHAN_NO_RESULTS) || (c == `CPU_R_CHAN_RES_RD) ||
           (c == `CPU_R_CHAN_RES_WR);
  endfunction

  task automatic clear_expect();
    e_pulse = 0; e_tmo = 0; e_msg = '0; e_data = '0; e_addr = '0;
    e_rsp_msg = '0; e_rsp_data = '0;
  endtask

  task automatic release_owner();
    m_last = m_own;
    m_own  = -1;
    m_rel  = 1;
  endtask

  task automatic model_step();
    clear_expect();
    if (rst) begin
      m_own = -1; m_rel = 0; m_fwd = 0; m_ptr = 0; m_cnt = 0;
    end else if (clk_oe) begin
      if (m_rel) begin
        m_ptr = (m_last + 1) % N;
        m_rel = 0;
      end else if (m_own < 0) begin
        if (disp_online && bus.req_i != '0) begin
          for (int k = 0; k < N; k++) begin
            int j = (m_ptr + k) % N;
            if (bus.req_i[j]) begin
              m_own = j;
              break;
            end
          end
          m_fwd = 0;
        end
      end else begin
        if (bus.req_pulse_i[m_own]) begin
          e_pulse = 1;
          e_msg   = bus.req_msg_i[m_own*MW +: MW];
          e_data  = bus.req_data_i[m_own*DW +: DW];
          e_addr  = bus.req_addr_i[m_own*AW +: AW];
        end
        if (!m_fwd) begin
          if (bus.req_pulse_i[m_own]) begin
            m_fwd = 1;
            m_cnt = 0;
          end else if (!bus.req_i[m_own]) begin
            release_owner();
          end
        end else begin
          e_rsp_msg[m_own*MW +: MW]  = bus.rsp_msg_i;
          e_rsp_data[m_own*DW +: DW] = bus.rsp_data_i;
          if (is_term(bus.rsp_msg_i)) begin
            release_owner();
          end
`ifdef CHAN_ARB_TIMEOUT_EN
          else if (m_cnt + 1 == TMO) begin
            e_tmo = 1;
            e_rsp_msg[m_own*MW +: MW]  = `CPU_R_CHAN_NO_RESULTS;
            e_rsp_data[m_own*DW +: DW] = '0;
            release_owner();
          end else begin
            m_cnt++;
          end
`endif
        end
      end
    end
  endtask

  // One clock: predict, advance, then compare every output against the model
  task automatic tick();
    logic [N-1:0] e_grant;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    e_grant = '0;
    if (m_own >= 0) e_grant[m_own] = 1'b1;
    check("grant",    bus.grant_o,     e_grant);
    check("busy",     bus.busy_o,      m_own >= 0);
    check("pulse",    bus.msg_pulse_o, e_pulse);
    check("msg",      bus.msg_out,     e_msg);
    check("data",     bus.data_out,    e_data);
    check("addr",     bus.addr_out,    e_addr);
    check("rsp_msg",  bus.rsp_msg_o,   e_rsp_msg);
    check("rsp_data", bus.rsp_data_o,  e_rsp_data);
    check("tmo",      bus.tmo_o,       e_tmo);
  endtask

  task automatic set_slot(input int i, input logic [MW-1:0] m, input logic [DW-1:0] d,
                          input logic [AW-1:0] a);
    bus.req_msg_i[i*MW +: MW]  = m;
    bus.req_data_i[i*DW +: DW] = d;
    bus.req_addr_i[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst = 1; bus.req_i = '0; bus.req_pulse_i = '0; bus.rsp_msg_i = '0; bus.rsp_data_i = '0;
    tick();
    rst = 0;
  endtask

  logic [N-1:0] seq [5];
  int           n;

  initial begin
    rst = 1; clk_oe = 1; disp_online = 1;
    bus.req_i = '0; bus.req_pulse_i = '0;
    bus.req_msg_i = '0; bus.req_data_i = '0; bus.req_addr_i = '0;
    bus.rsp_msg_i = '0; bus.rsp_data_i = '0;
    tick(); tick();
    check("reset_grant", bus.grant_o, '0);
    check("reset_busy",  bus.busy_o,  1'b0);

    // Reset after a grant clears everything; requester 0 is granted again
    rst = 0; bus.req_i = 4'b0001;
    tick();
    rst = 1; tick();
    check("rst_after_grant", bus.grant_o, 4'b0000);
    rst = 0; tick();
    check("regrant_req0", bus.grant_o, 4'b0001);
    bus.req_i = '0; tick(); tick();

    // Full transaction from requester 1, then requester 3 is next
    do_reset();
    bus.req_i = 4'b1010; tick();
    check("tp2_grant", bus.grant_o, 4'b0010);
    set_slot(1, `CPU_R_CHAN_GET, 32'h0000_00AA, 32'h40);
    bus.req_pulse_i = 4'b0010; tick();
    check("tp2_msg0",  bus.msg_out,  `CPU_R_CHAN_GET);
    check("tp2_addr0", bus.addr_out, 32'h40);
    set_slot(1, `CPU_R_THREAD_ADDRESS, 32'h0000_BEEF, 32'h80);
    tick();
    check("tp2_msg1", bus.msg_out, `CPU_R_THREAD_ADDRESS);
    bus.req_pulse_i = '0; bus.rsp_msg_i = `CPU_R_CHAN_RES_RD; bus.rsp_data_i = 32'h1234;
    tick();
    check("tp2_rsp_msg",  bus.rsp_msg_o,  {8'h00, 8'h00, `CPU_R_CHAN_RES_RD, 8'h00});
    check("tp2_rsp_data", bus.rsp_data_o, {32'h0, 32'h0, 32'h1234, 32'h0});
    bus.rsp_msg_i = '0; bus.rsp_data_i = '0; bus.req_i = 4'b1000;
    tick(); tick(); tick();
    check("tp2_next_grant", bus.grant_o, 4'b1000);
    bus.req_i = '0; tick(); tick();

    // All four requesting: grants rotate
    do_reset();
    bus.req_i = 4'b1111;
    for (int i = 0; i < N; i++) set_slot(i, `CPU_R_CHAN_SET, 32'(i), 32'(i * 16));
    for (int t = 0; t < 5; t++) begin
      for (int w = 0; w < 10 && bus.grant_o == '0; w++) tick();
      seq[t] = bus.grant_o;
      bus.req_pulse_i = bus.grant_o; tick();
      bus.req_pulse_i = '0; bus.rsp_msg_i = `CPU_R_CHAN_RES_WR; tick();
      bus.rsp_msg_i = '0;
    end
    check("rot0", seq[0], 4'b0001);
    check("rot1", seq[1], 4'b0010);
    check("rot2", seq[2], 4'b0100);
    check("rot3", seq[3], 4'b1000);
    check("rot4", seq[4], 4'b0001);
    bus.req_i = '0; tick(); tick();

    // Pulse from a non-granted requester is dropped
    do_reset();
    bus.req_i = 4'b0101; tick();
    set_slot(0, `CPU_R_CHAN_GET, 32'h1111, 32'h11);
    set_slot(2, `CPU_R_CHAN_SET, 32'h2222, 32'h22);
    bus.req_pulse_i = 4'b0100; tick();
    check("foreign_pulse", bus.msg_pulse_o, 1'b0);
    bus.req_pulse_i = 4'b0001; tick();
    check("owner_msg",  bus.msg_out,  `CPU_R_CHAN_GET);
    check("owner_data", bus.data_out, 32'h1111);
    bus.req_pulse_i = '0; bus.rsp_msg_i = `CPU_R_CHAN_RES_WR; tick();
    bus.rsp_msg_i = '0; bus.req_i = '0; tick(); tick();

    // Dispatcher offline blocks new grants
    do_reset();
    disp_online = 0; bus.req_i = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("offline_nogrant", bus.grant_o, 4'b0000);
    end
    disp_online = 1; tick();
    check("online_grant", bus.grant_o, 4'b0001);
    bus.req_i = '0; tick(); tick();

`ifdef CHAN_ARB_TIMEOUT_EN
    // No response: timeout after TMO qualified cycles in WAIT
    do_reset();
    bus.req_i = 4'b0010; tick();
    set_slot(1, `CPU_R_CHAN_GET, 32'h5, 32'h40);
    bus.req_pulse_i = 4'b0010; tick();
    bus.req_pulse_i = '0;
    n = 0;
    do begin tick(); n++; end while (!bus.tmo_o && n < 40);
    check("tmo_latency", 32'(n), 32'(TMO));
    check("tmo_rsp", bus.rsp_msg_o[15:8], `CPU_R_CHAN_NO_RESULTS);
    check("tmo_release", bus.grant_o, 4'b0000);
    for (int w = 0; w < 10 && bus.grant_o == '0; w++) tick();
    bus.req_pulse_i = 4'b0010; tick();
    bus.req_pulse_i = '0;
    n = 0;
    do begin clk_oe = (n % 2 == 1); tick(); n++; end while (!bus.tmo_o && n < 80);
    check("tmo_latency_half", 32'(n), 32'(2 * TMO));
    clk_oe = 1; bus.req_i = '0; tick(); tick();
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 2500; c++) begin
      rst         = ($urandom_range(0, 299) == 0);
      clk_oe      = ($urandom_range(0, 7) != 0);
      disp_online = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) bus.req_i = 4'($urandom);
      bus.req_pulse_i = 4'($urandom) & 4'($urandom);
      bus.req_msg_i   = $urandom;
      bus.req_data_i  = {$urandom, $urandom, $urandom, $urandom};
      bus.req_addr_i  = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 5))
        1:       bus.rsp_msg_i = 8'h55;
        2:       bus.rsp_msg_i = `CPU_R_CHAN_NO_RESULTS;
        3:       bus.rsp_msg_i = `CPU_R_CHAN_RES_RD;
        4:       bus.rsp_msg_i = `CPU_R_CHAN_RES_WR;
        default: bus.rsp_msg_i = 8'h00;
      endcase
      bus.rsp_data_i = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
